// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
//   Shared definitions for the 7-segment scan controller:
//   - scan_state_t : scan FSM encoding (IDLE / BLANK / SHOW)
//   - SEG_OFF      : all segments and decimal point dark
//   - SEG_0..SEG_9 : common-cathode {g,f,e,d,c,b,a} patterns, high = lit
//   - digit_pattern: maps a BCD value to its segment pattern (10-15 -> off)
// ---------------------------------------------------------------------------
package seg7_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,   // scanning stopped, display dark
      ST_BLANK = 2'd1,   // start of slot, all digits off (anti-ghosting gap)
      ST_SHOW  = 2'd2    // current digit driven
   } scan_state_t;

   localparam logic [7:0] SEG_OFF = 8'h00;

   // Bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;

   function automatic logic [6:0] digit_pattern(input logic [3:0] value);
      logic [6:0] pattern;
      case (value)
         4'd0:    pattern = SEG_0;
         4'd1:    pattern = SEG_1;
         4'd2:    pattern = SEG_2;
         4'd3:    pattern = SEG_3;
         4'd4:    pattern = SEG_4;
         4'd5:    pattern = SEG_5;
         4'd6:    pattern = SEG_6;
         4'd7:    pattern = SEG_7;
         4'd8:    pattern = SEG_8;
         4'd9:    pattern = SEG_9;
         default: pattern = 7'h00;   // 10-15 render as a dark digit
      endcase
      return pattern;
   endfunction

endpackage

// File: rtl/SevenSEG.sv
// ---------------------------------------------------------------------------
// SevenSEG
//   Combinational 7-segment decoder for a common-cathode digit.
//   Ports:
//     hex  in  5  value to show; 0-9 lit, anything else (10-31) segments off
//     dp   in  1  decimal point, 1 = lit (independent of hex)
//     seg  out 8  {dp,g,f,e,d,c,b,a}, high = lit
// ---------------------------------------------------------------------------
module SevenSEG
   import seg7_pkg::*;
(
   input  logic [4:0] hex,
   input  logic       dp,
   output logic [7:0] seg
);

   always_comb begin
      seg = {dp, 7'h00};
      if (!hex[4]) begin
         seg[6:0] = digit_pattern(hex[3:0]);
      end
   end

endmodule

// File: rtl/seg7_slot_timer.sv
// ---------------------------------------------------------------------------
// seg7_slot_timer
//   Slot timing for the scan controller. A slot is SLOT_CYC clocks; the first
//   BLANK_CYC of them are the blanking gap. The digit index advances at the
//   end of every slot and wraps after DIGITS-1.
//   Ports:
//     clk         in   1      rising-edge clock
//     rst         in   1      asynchronous active-high reset
//     run         in   1      1 = count; 0 = hold counter and index at 0
//     index       out  IDX_W  digit currently being scanned
//     blank_done  out  1      last clock of the blanking gap
//     slot_done   out  1      last clock of the slot
//     frame_done  out  1      last clock of the slot of digit DIGITS-1
// ---------------------------------------------------------------------------
module seg7_slot_timer #(
   parameter int DIGITS    = 4,
   parameter int SLOT_CYC  = 50000,
   parameter int BLANK_CYC = 16,
   parameter int IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1,
   parameter int CNT_W     = $clog2(SLOT_CYC)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   output logic [IDX_W-1:0] index,
   output logic             blank_done,
   output logic             slot_done,
   output logic             frame_done
);

   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SLOT_CYC - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);

   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;
   logic [IDX_W-1:0] index_reg;
   logic [IDX_W-1:0] index_next;

   always_comb begin
      count_next = count_reg;
      index_next = index_reg;
      if (!run) begin
         // Stopping the scan always restarts from the beginning of slot 0
         count_next = '0;
         index_next = '0;
      end else if (count_reg == LAST_CNT) begin
         count_next = '0;
         index_next = (index_reg == LAST_IDX) ? '0 : index_reg + 1'b1;
      end else begin
         count_next = count_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
         index_reg <= '0;
      end else begin
         count_reg <= count_next;
         index_reg <= index_next;
      end
   end

   assign index      = index_reg;
   assign blank_done = run && (count_reg == BLANK_END);
   assign slot_done  = run && (count_reg == LAST_CNT);
   assign frame_done = slot_done && (index_reg == LAST_IDX);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//   Time-multiplexed scan controller for a DIGITS-wide common-cathode
//   7-segment bank. The application loads a digit/dp image through a
//   valid/ready handshake into a shadow buffer; the shadow is copied to the
//   display buffer only at a frame boundary (or while idle) so a frame never
//   mixes two images. Each digit slot starts with a blanking gap.
//   Ports:
//     clk          in   1         rising-edge clock
//     rst          in   1         asynchronous active-high reset
//     enable       in   1         1 = scan; 0 = display dark, scan held
//     lz_suppress  in   1         1 = blank leading zeros
//     load_valid   in   1         new image offered
//     load_ready   out  1         image can be accepted (no image pending)
//     load_digits  in   4*DIGITS  digit i at [4i+3:4i]; 10-15 = digit off
//     load_dp      in   DIGITS    decimal point per digit, 1 = lit
//     seg_out      out  8         {dp,g..a}, high = lit (registered)
//     dig_en       out  DIGITS    one-hot digit enable, high = on (registered)
// ---------------------------------------------------------------------------
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int DIGITS    = 4,
   parameter int SLOT_CYC  = 50000,
   parameter int BLANK_CYC = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  lz_suppress,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [4*DIGITS-1:0]   load_digits,
   input  logic [DIGITS-1:0]     load_dp,
   output logic [7:0]            seg_out,
   output logic [DIGITS-1:0]     dig_en
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // ------------------------------------------------------------------
   // State and buffers
   // ------------------------------------------------------------------
   scan_state_t          state_reg;
   scan_state_t          state_next;

   logic [4*DIGITS-1:0]  shadow_digits_reg;
   logic [DIGITS-1:0]    shadow_dp_reg;
   logic [4*DIGITS-1:0]  display_digits_reg;
   logic [DIGITS-1:0]    display_dp_reg;
   logic                 pending_reg;
   logic                 pending_next;
   logic                 load_ready_reg;

   logic [7:0]           seg_reg;
   logic [7:0]           seg_next;
   logic [DIGITS-1:0]    dig_en_reg;
   logic [DIGITS-1:0]    dig_en_next;

   // ------------------------------------------------------------------
   // Slot timing
   // ------------------------------------------------------------------
   logic                 timer_run;
   logic [IDX_W-1:0]     digit_index;
   logic                 blank_done;
   logic                 slot_done;
   logic                 frame_done;

   // The timer only advances while actively scanning; dropping enable clears
   // it on the same edge the FSM returns to IDLE.
   assign timer_run = enable && (state_reg != ST_IDLE);

   seg7_slot_timer #(
      .DIGITS    (DIGITS),
      .SLOT_CYC  (SLOT_CYC),
      .BLANK_CYC (BLANK_CYC),
      .IDX_W     (IDX_W)
   ) u_slot_timer (
      .clk        (clk),
      .rst        (rst),
      .run        (timer_run),
      .index      (digit_index),
      .blank_done (blank_done),
      .slot_done  (slot_done),
      .frame_done (frame_done)
   );

   // ------------------------------------------------------------------
   // Leading-zero detection on the display image.
   // blank_lead[i]: digit i and every digit above it are zero. Digit 0 is
   // never suppressed so an all-zero image still shows a single "0".
   // ------------------------------------------------------------------
   logic [DIGITS-1:0] nonzero;
   logic [DIGITS-1:0] blank_lead;

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lead
      assign nonzero[gi]    = |display_digits_reg[gi*4 +: 4];
      assign blank_lead[gi] = (gi != 0) && !(|(nonzero >> gi));
   end

   // ------------------------------------------------------------------
   // Current-digit selection and decode
   // ------------------------------------------------------------------
   logic [3:0]        digit_sel;
   logic              dp_sel;
   logic              lead_sel;
   logic [DIGITS-1:0] digit_onehot;
   logic [7:0]        seg_raw;
   logic [7:0]        seg_shown;

   always_comb begin
      digit_sel    = '0;
      dp_sel       = 1'b0;
      lead_sel     = 1'b0;
      digit_onehot = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (digit_index == IDX_W'(i)) begin
            digit_sel       = display_digits_reg[i*4 +: 4];
            dp_sel          = display_dp_reg[i];
            lead_sel        = blank_lead[i];
            digit_onehot[i] = 1'b1;
         end
      end
   end

   SevenSEG u_decoder (
      .hex (({1'b0, digit_sel})),
      .dp  (dp_sel),
      .seg (seg_raw)
   );

   // Suppressed leading zeros lose segments a-g but keep their decimal point
   assign seg_shown = (lz_suppress && lead_sel) ? {seg_raw[7], 7'h00} : seg_raw;

   // ------------------------------------------------------------------
   // Scan FSM
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      if (!enable) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE:  state_next = ST_BLANK;
            ST_BLANK: if (blank_done) state_next = ST_SHOW;
            ST_SHOW:  if (slot_done)  state_next = ST_BLANK;
            default:  state_next = ST_IDLE;
         endcase
      end
   end

   // Output image for the next clock. Gating with enable makes the display
   // go dark on the same edge the FSM leaves SHOW for IDLE.
   always_comb begin
      seg_next    = SEG_OFF;
      dig_en_next = '0;
      if (enable && (state_reg == ST_SHOW)) begin
         seg_next    = seg_shown;
         dig_en_next = digit_onehot;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         seg_reg    <= SEG_OFF;
         dig_en_reg <= '0;
      end else begin
         state_reg  <= state_next;
         seg_reg    <= seg_next;
         dig_en_reg <= dig_en_next;
      end
   end

   // ------------------------------------------------------------------
   // Load handshake and double buffering
   // ------------------------------------------------------------------
   logic accept;
   logic transfer;

   assign accept   = load_valid && load_ready_reg;
   // Shadow moves to display only between frames, or at any time when idle.
   // accept and transfer are mutually exclusive: accept needs pending low.
   assign transfer = pending_reg && ((state_reg == ST_IDLE) || frame_done);

   always_comb begin
      pending_next = pending_reg;
      if (accept) begin
         pending_next = 1'b1;
      end else if (transfer) begin
         pending_next = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_digits_reg  <= '0;
         shadow_dp_reg      <= '0;
         display_digits_reg <= '0;
         display_dp_reg     <= '0;
         pending_reg        <= 1'b0;
         load_ready_reg     <= 1'b1;
      end else begin
         if (accept) begin
            shadow_digits_reg <= load_digits;
            shadow_dp_reg     <= load_dp;
         end
         if (transfer) begin
            display_digits_reg <= shadow_digits_reg;
            display_dp_reg     <= shadow_dp_reg;
         end
         pending_reg    <= pending_next;
         load_ready_reg <= !pending_next;
      end
   end

   assign load_ready = load_ready_reg;
   assign seg_out    = seg_reg;
   assign dig_en     = dig_en_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

   localparam int DIGITS    = 4;
   localparam int SLOT_CYC  = 20;
   localparam int BLANK_CYC = 4;
   localparam int FRAME_CYC = DIGITS * SLOT_CYC;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        lz_suppress = 1'b0;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic [15:0] load_digits = '0;
   logic [3:0]  load_dp = '0;
   logic [7:0]  seg_out;
   logic [3:0]  dig_en;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   seg7_scan_ctrl #(
      .DIGITS    (DIGITS),
      .SLOT_CYC  (SLOT_CYC),
      .BLANK_CYC (BLANK_CYC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .lz_suppress (lz_suppress),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_digits (load_digits),
      .load_dp     (load_dp),
      .seg_out     (seg_out),
      .dig_en      (dig_en)
   );

   // Expected segment bytes per image, packed {digit3,digit2,digit1,digit0}
   localparam logic [31:0] S1234 = 32'h065B4F66;
   localparam logic [31:0] S5678 = 32'h6D7D077F;
   localparam logic [31:0] S4321 = 32'h664F5B06;
   localparam logic [31:0] SZERO = 32'h3F3F3F3F;

   typedef struct {
      logic [15:0] digits;
      logic [3:0]  dp;
      logic        lz;
      logic [31:0] segs;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input int k, input logic [31:0] act,
                        input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, req);
      end
   endtask

   // Expected {dig_en, seg_out} k clocks after the edge that sees enable=1
   // from IDLE. One dark cycle from IDLE, then per slot: BLANK_CYC dark,
   // SLOT_CYC-BLANK_CYC lit. Frame 0 uses f0, later frames f1.
   function automatic logic [11:0] exp_out(input int k, input logic [31:0] f0,
                                           input logic [31:0] f1);
      int c;
      int pos;
      int slot;
      logic [3:0] oh;
      logic [7:0] s;
      if (k < 2) return 12'h000;
      c    = k - 2;
      pos  = c % SLOT_CYC;
      slot = (c / SLOT_CYC) % DIGITS;
      if (pos < BLANK_CYC) return 12'h000;
      oh = 4'b0001;
      oh = oh << slot;
      s  = (c >= FRAME_CYC) ? f1[slot*8 +: 8] : f0[slot*8 +: 8];
      return {oh, s};
   endfunction

   task automatic step(input int k, input logic [31:0] f0, input logic [31:0] f1,
                       input string name);
      @(posedge clk);
      #1;
      check(name, k, {20'h0, dig_en, seg_out}, {20'h0, exp_out(k, f0, f1)});
   endtask

   // Stop scanning and load an image; it reaches the display while idle.
   task automatic idle_load(input logic [15:0] d, input logic [3:0] p);
      int waited;
      enable = 1'b0;
      @(posedge clk);
      #1;
      check("dark_after_disable", 0, {20'h0, dig_en, seg_out}, 32'h0);
      waited = 0;
      while (!load_ready && waited < 200) begin
         @(posedge clk);
         #1;
         waited++;
      end
      check("ready_before_load", waited, {31'h0, load_ready}, 32'h1);
      load_digits = d;
      load_dp     = p;
      load_valid  = 1'b1;
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      check("ready_drop_on_accept", 0, {31'h0, load_ready}, 32'h0);
      @(posedge clk);
      #1;
      check("ready_after_idle_xfer", 0, {31'h0, load_ready}, 32'h1);
   endtask

   initial begin
      vecs[0] = '{16'h1234, 4'b0000, 1'b0, S1234};
      vecs[1] = '{16'h0070, 4'b0100, 1'b1, 32'h0080073F};
      vecs[2] = '{16'h0070, 4'b0100, 1'b0, 32'h3FBF073F};
      vecs[3] = '{16'h5C90, 4'b0100, 1'b0, 32'h6D806F3F};
      vecs[4] = '{16'h0000, 4'b0001, 1'b1, 32'h000000BF};
      vecs[5] = '{16'h8FA9, 4'b1010, 1'b1, 32'hFF00806F};
      vecs[6] = '{16'h0105, 4'b0000, 1'b1, 32'h00063F6D};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", 0, {20'h0, dig_en, seg_out}, 32'h0);
      check("reset_ready", 0, {31'h0, load_ready}, 32'h1);
      rst = 1'b0;

      // Table: one full frame per image
      for (int v = 0; v < 7; v++) begin
         lz_suppress = vecs[v].lz;
         idle_load(vecs[v].digits, vecs[v].dp);
         enable = 1'b1;
         for (int k = 1; k <= FRAME_CYC + 1; k++) step(k, vecs[v].segs, vecs[v].segs, "scan_vec");
         $display("vector %0d digits=%h dp=%b lz=%0b segs=%h checked", v,
                  vecs[v].digits, vecs[v].dp, vecs[v].lz, vecs[v].segs);
      end

      // Load mid-frame: current frame finishes with the old image
      lz_suppress = 1'b0;
      idle_load(16'h1234, 4'b0000);
      enable = 1'b1;
      for (int k = 1; k <= 30; k++) step(k, S1234, S1234, "scanA_pre");
      load_digits = 16'h5678;
      load_dp     = 4'b0000;
      load_valid  = 1'b1;
      step(31, S1234, S5678, "scanA_load");
      load_valid = 1'b0;
      check("scanA_ready_drop", 31, {31'h0, load_ready}, 32'h0);
      for (int k = 32; k <= 101; k++) begin
         step(k, S1234, S5678, "scanA");
         check("scanA_ready", k, {31'h0, load_ready}, {31'h0, (k >= FRAME_CYC + 1) ? 1'b1 : 1'b0});
      end
      $display("sequence midframe_load checked");

      // Disable during SHOW of digit 2, pending image transfers while idle
      idle_load(16'h1234, 4'b0000);
      enable = 1'b1;
      for (int k = 1; k <= 39; k++) step(k, S1234, S1234, "scanB_pre");
      load_digits = 16'h4321;
      load_valid  = 1'b1;
      step(40, S1234, S1234, "scanB_load");
      load_valid = 1'b0;
      for (int k = 41; k <= 50; k++) step(k, S1234, S1234, "scanB_pre");
      check("scanB_digit2_lit", 50, {28'h0, dig_en}, 32'h4);
      enable = 1'b0;
      @(posedge clk);
      #1;
      check("scanB_dark", 51, {20'h0, dig_en, seg_out}, 32'h0);
      check("scanB_pending", 51, {31'h0, load_ready}, 32'h0);
      @(posedge clk);
      #1;
      check("scanB_idle_xfer", 52, {31'h0, load_ready}, 32'h1);
      enable = 1'b1;
      for (int k = 1; k <= 30; k++) step(k, S4321, S4321, "scanB_reenable");
      $display("sequence disable_mid_show checked");

      // Async reset mid-SHOW with a pending image
      load_digits = 16'h9999;
      load_dp     = 4'b1111;
      load_valid  = 1'b1;
      step(31, S4321, S4321, "scanC_load");
      load_valid = 1'b0;
      check("scanC_pending", 31, {31'h0, load_ready}, 32'h0);
      for (int k = 32; k <= 50; k++) step(k, S4321, S4321, "scanC_pre");
      #2;
      rst = 1'b1;
      #1;
      check("scanC_async_dark", 0, {20'h0, dig_en, seg_out}, 32'h0);
      check("scanC_async_ready", 0, {31'h0, load_ready}, 32'h1);
      #2;
      rst = 1'b0;
      for (int k = 1; k <= 30; k++) step(k, SZERO, SZERO, "scanC_after_reset");
      check("scanC_ready_end", 30, {31'h0, load_ready}, 32'h1);
      $display("sequence async_reset checked");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
